// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and forwarding selects.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_NOR   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    // Select 2'b11 is reserved and behaves like FWD_RF.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational 3-bit-op ALU with zero flag and signed ADD/SUB overflow.
module alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt_signed;

    assign sum       = src_a + src_b;
    assign diff      = src_a - src_b;
    assign lt_signed = $signed(src_a) < $signed(src_b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result   = sum;
                overflow = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);
            end
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_NOR: result = ~(src_a | src_b);
            default: result = src_b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: forwarding and ALUSrc muxes, ALU, and the EX/MEM pipeline register.
module execute_cycle
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              StallM,
    input  logic              FlushM,
    output logic              ZeroE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic              OverflowM
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;

    // Forward-from-M taps the registered ALUResultM, so a stalled M stage feeds a stable value.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data = RD2_E;
        case (ForwardBE)
            FWD_W:   write_data = ResultW;
            FWD_M:   write_data = ALUResultM;
            default: write_data = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_data;

    alu #(.DATA_W(DATA_W)) u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (ALUControlE),
        .result      (alu_result),
        .zero        (ZeroE),
        .overflow    (alu_overflow)
    );

    // Stall wins over flush; a bubble clears control and RD_M but leaves the data registers alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            OverflowM  <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (StallM) begin
            RegWriteM  <= RegWriteM;
        end else if (FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            OverflowM  <= 1'b0;
            RD_M       <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            OverflowM  <= alu_overflow;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle against a behavioural model of the EX stage.
module tb_execute_cycle;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write, alu_src, mem_write, result_src;
    logic [2:0]  alu_ctl;
    logic [31:0] rd1, rd2, imm, pc4, result_w;
    logic [4:0]  rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush;

    logic        ZeroE, RegWriteM, MemWriteM, ResultSrcM, OverflowM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [104:0] dut_vec;

    int checks = 0;
    int failures = 0;

    logic        m_rw, m_mw, m_rs, m_ovf;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc;

    logic [31:0] sweep_res [8] = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001,
                                   32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE, 32'h0000_0001};
    logic        sweep_ovf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(reg_write), .ALUSrcE(alu_src), .MemWriteE(mem_write), .ResultSrcE(result_src),
        .ALUControlE(alu_ctl), .RD1_E(rd1), .RD2_E(rd2), .Imm_Ext_E(imm), .RD_E(rd),
        .PCPlus4E(pc4), .ResultW(result_w), .ForwardAE(fwd_a), .ForwardBE(fwd_b),
        .StallM(stall), .FlushM(flush), .ZeroE(ZeroE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .OverflowM(OverflowM)
    );

    assign dut_vec = {RegWriteM, MemWriteM, ResultSrcM, OverflowM, RD_M, ALUResultM, WriteDataM, PCPlus4M};

    function automatic logic [104:0] model_vec();
        return {m_rw, m_mw, m_rs, m_ovf, m_rd, m_alu, m_wd, m_pc};
    endfunction

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return ~(a | b);
            default: return b;
        endcase
    endfunction

    // Overflow means the exact signed result does not fit back into 32 bits.
    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic signed [31:0] lo;
        if (op > 3'd1) return 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = (op == 3'd0) ? sa + sb : sa - sb;
        lo = s[31:0];
        return longint'(lo) != s;
    endfunction

    function automatic logic model_zero();
        logic [31:0] a, wd, b;
        a  = fwd_val(fwd_a, rd1, result_w, m_alu);
        wd = fwd_val(fwd_b, rd2, result_w, m_alu);
        b  = alu_src ? imm : wd;
        return ref_alu(alu_ctl, a, b) == 32'd0;
    endfunction

    task automatic model_clear();
        m_rw = 0; m_mw = 0; m_rs = 0; m_ovf = 0; m_rd = '0; m_alu = '0; m_wd = '0; m_pc = '0;
    endtask

    // Advance one clock edge, updating the model, and return at the following falling edge.
    task automatic cycle();
        logic [31:0] a, wd, b, r;
        logic o;
        a  = fwd_val(fwd_a, rd1, result_w, m_alu);
        wd = fwd_val(fwd_b, rd2, result_w, m_alu);
        b  = alu_src ? imm : wd;
        r  = ref_alu(alu_ctl, a, b);
        o  = ref_ovf(alu_ctl, a, b);
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else if (stall) begin
            m_rw = m_rw;
        end else if (flush) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_ovf = 0; m_rd = '0;
        end else begin
            m_rw = reg_write; m_mw = mem_write; m_rs = result_src; m_ovf = o;
            m_rd = rd; m_alu = r; m_wd = wd; m_pc = pc4;
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        reg_write = 1'($urandom); alu_src = 1'($urandom); mem_write = 1'($urandom);
        result_src = 1'($urandom); alu_ctl = 3'($urandom);
        rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc4 = $urandom; result_w = $urandom;
        rd = 5'($urandom); fwd_a = 2'($urandom); fwd_b = 2'($urandom);
        if ($urandom_range(0, 3) == 0) rd2 = rd1;
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 7) == 0);
    endtask

    task automatic drive_clean();
        rand_inputs();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        rand_inputs();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 105'd0) begin
            failures++;
            $display("FAIL reset_async actual=%h required=0", dut_vec);
        end
        cycle();
        rand_inputs();
        cycle();
        checks++;
        if (dut_vec !== 105'd0) begin
            failures++;
            $display("FAIL reset_held actual=%h required=0", dut_vec);
        end
        drive_clean();
        rd1 = 32'd5; rd2 = 32'd7; alu_ctl = OP_ADD;
        #1;
        checks++;
        if (ZeroE !== 1'b0) begin
            failures++;
            $display("FAIL reset_zeroe actual=%b required=0", ZeroE);
        end
        cycle();
        checks++;
        if (ALUResultM !== 32'd12) begin
            failures++;
            $display("FAIL reset_first_add actual=%h required=%h", ALUResultM, 32'd12);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL reset_first_bundle actual=%h required=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_alu_sweep();
        for (int i = 0; i < 8; i++) begin
            drive_clean();
            rd1 = 32'h8000_0000; rd2 = 32'd1; alu_ctl = 3'(i);
            cycle();
            checks++;
            if (ALUResultM !== sweep_res[i] || OverflowM !== sweep_ovf[i]) begin
                failures++;
                $display("FAIL alu_sweep op=%0d actual=%h/%b required=%h/%b",
                         i, ALUResultM, OverflowM, sweep_res[i], sweep_ovf[i]);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL alu_sweep_bundle op=%0d actual=%h required=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_alusrc_zero();
        drive_clean();
        rd1 = 32'd3; imm = 32'd3; alu_src = 1'b1; alu_ctl = OP_SUB;
        if (rd2 == 32'd0) rd2 = 32'h1234;
        #1;
        checks++;
        if (ZeroE !== 1'b1) begin
            failures++;
            $display("FAIL alusrc_zeroe actual=%b required=1", ZeroE);
        end
        cycle();
        checks++;
        if (ALUResultM !== 32'd0 || WriteDataM !== rd2 || OverflowM !== 1'b0) begin
            failures++;
            $display("FAIL alusrc_result actual=%h/%h/%b required=0/%h/0", ALUResultM, WriteDataM, OverflowM, rd2);
        end
    endtask

    task automatic test_forwarding();
        drive_clean();
        rd1 = 32'h10; rd2 = 32'd0; alu_ctl = OP_ADD;
        cycle();
        drive_clean();
        fwd_a = 2'b10; fwd_b = 2'b01; result_w = 32'h20; alu_ctl = OP_ADD;
        cycle();
        checks++;
        if (ALUResultM !== 32'h30 || WriteDataM !== 32'h20) begin
            failures++;
            $display("FAIL forward_mw actual=%h/%h required=30/20", ALUResultM, WriteDataM);
        end
        drive_clean();
        fwd_a = 2'b11; fwd_b = 2'b11; rd1 = 32'd100; rd2 = 32'd23; alu_ctl = OP_ADD;
        cycle();
        checks++;
        if (ALUResultM !== 32'd123 || WriteDataM !== 32'd23) begin
            failures++;
            $display("FAIL forward_reserved actual=%h/%h required=%h/%h", ALUResultM, WriteDataM, 32'd123, 32'd23);
        end
    endtask

    task automatic test_stall_flush();
        logic [104:0] snap;
        drive_clean();
        reg_write = 1'b1; mem_write = 1'b1; result_src = 1'b1; rd = 5'd5;
        cycle();
        snap = model_vec();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            stall = 1'b1;
            cycle();
            checks++;
            if (dut_vec !== snap) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d actual=%h required=%h", i, dut_vec, snap);
            end
        end
        drive_clean();
        flush = 1'b1;
        cycle();
        checks++;
        if ({RegWriteM, MemWriteM, ResultSrcM, OverflowM, RD_M} !== 9'd0 || ALUResultM !== snap[95:64]) begin
            failures++;
            $display("FAIL flush_bubble actual=%h required=%h", dut_vec, model_vec());
        end
        drive_clean();
        reg_write = 1'b1; rd = 5'd7;
        cycle();
        snap = model_vec();
        rand_inputs();
        stall = 1'b1; flush = 1'b1;
        cycle();
        checks++;
        if (dut_vec !== snap) begin
            failures++;
            $display("FAIL stall_flush_hold actual=%h required=%h", dut_vec, snap);
        end
    endtask

    task automatic test_async_reset();
        drive_clean();
        reg_write = 1'b1; rd = 5'd9; pc4 = 32'h44;
        cycle();
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL async_preload actual=%h required=%h", dut_vec, model_vec());
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 105'd0) begin
            failures++;
            $display("FAIL async_clear actual=%h required=0", dut_vec);
        end
        model_clear();
        #1;
        drive_clean();
        reg_write = 1'b1;
        cycle();
        checks++;
        if (dut_vec !== model_vec() || RegWriteM !== 1'b1) begin
            failures++;
            $display("FAIL async_resume actual=%h required=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            #1;
            checks++;
            if (ZeroE !== model_zero()) begin
                failures++;
                $display("FAIL random_zeroe it=%0d actual=%b required=%b", i, ZeroE, model_zero());
            end
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_bundle it=%0d actual=%h required=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_sweep();
        test_alusrc_zero();
        test_forwarding();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
